sprite_anim_src: RTL and testbench

Parametrised, animated sprite source for the pixel pipeline. Each cycle it maps the scan coordinate to a pixel of a multi-frame, multi-colour sprite stored in an internal dual-port RAM. It looks the pixel up in a programmable palette and emits either the colour or the chroma key. The sprite frame advances automatically on frame ticks; optional horizontal mirroring is provided. Output feeds the layer mixer alongside the other sprite sources.

---
 rtl/sprite_anim_src_if.sv | 22 ++
 rtl/sprite_anim_src.sv | 149 ++++++++++++++
 tb/tb_sprite_anim_src.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_anim_src_if.sv
// Write bus for sprite_anim_src: sprite RAM pixel writes and palette entry writes.
// The source side drives through master; the sprite block receives through slave.
interface sprite_anim_src_if #(
  parameter int CD   = 12,
  parameter int PW   = 2,
  parameter int ADDR = 14
);
  logic            we;
  logic [ADDR-1:0] addr_w;
  logic [PW-1:0]   pixel_in;
  logic            plt_we;
  logic [PW-1:0]   plt_addr;
  logic [CD-1:0]   plt_data;

  modport master (
    output we, addr_w, pixel_in, plt_we, plt_addr, plt_data
  );

  modport slave (
    input we, addr_w, pixel_in, plt_we, plt_addr, plt_data
  );
endinterface

// File: rtl/sprite_anim_src.sv
// Animated multi-frame palette sprite source with a two-stage pipeline (address/RAM read, then palette/output).
// Optional SPRITE_ANIM_HFLIP_EN: when defined, hflip mirrors sprite columns; otherwise hflip is ignored.
module sprite_anim_src #(
  parameter int             CD        = 12,
  parameter int             PW        = 2,
  parameter int             H_SIZE    = 64,
  parameter int             V_SIZE    = 64,
  parameter int             FRAMES    = 4,
  parameter logic [CD-1:0]  KEY_COLOR = '0,
  localparam int            HB        = $clog2(H_SIZE),
  localparam int            VB        = $clog2(V_SIZE),
  localparam int            FB        = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int            ADDR      = FB + VB + HB
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [10:0]          x,
  input  logic [10:0]          y,
  input  logic [10:0]          x0,
  input  logic [10:0]          y0,
  input  logic                 frame_tick,
  input  logic                 anim_en,
  input  logic [3:0]           anim_div,
  input  logic                 hflip,
  sprite_anim_src_if.slave     wr,
  output logic [FB-1:0]        cur_frame,
  output logic [CD-1:0]        sprite_rgb
);

  logic [11:0]     xr;
  logic [11:0]     yr;
  logic            in_region;
  logic [HB-1:0]   xc;
  logic [ADDR-1:0] addr_r;

  // Negative offsets set bit 11, so a zero upper slice is both the >=0 and <SIZE test.
  assign xr        = {1'b0, x} - {1'b0, x0};
  assign yr        = {1'b0, y} - {1'b0, y0};
  assign in_region = (xr[11:HB] == '0) && (yr[11:VB] == '0);

`ifdef SPRITE_ANIM_HFLIP_EN
  assign xc = hflip ? ~xr[HB-1:0] : xr[HB-1:0];
`else
  logic unused_hflip;
  assign unused_hflip = hflip;
  assign xc = xr[HB-1:0];
`endif

  logic [FB-1:0] frame_reg;
  assign addr_r    = {frame_reg, yr[VB-1:0], xc};
  assign cur_frame = frame_reg;

  // Sprite RAM: read-before-write on a shared address, contents never cleared.
  logic [PW-1:0] ram [2**ADDR];
  logic [PW-1:0] code_s1_reg;

  always_ff @(posedge clk) begin
    if (wr.we) begin
      ram[wr.addr_w] <= wr.pixel_in;
    end
    code_s1_reg <= ram[addr_r];
  end

  logic region_s1_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region_s1_reg <= 1'b0;
    end else begin
      region_s1_reg <= in_region;
    end
  end

  logic [2**PW-1:0] plt_sel;
  logic [CD-1:0]    palette_reg [2**PW];

  genvar gi;
  generate
    for (gi = 0; gi < 2**PW; gi++) begin : g_plt_sel
      assign plt_sel[gi] = wr.plt_we && (wr.plt_addr == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**PW; i++) begin
        palette_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2**PW; i++) begin
        if (plt_sel[i]) begin
          palette_reg[i] <= wr.plt_data;
        end
      end
    end
  end

  logic [CD-1:0] sprite_rgb_reg;
  logic [CD-1:0] sprite_rgb_next;

  // Code 0 is always transparent, whatever palette entry 0 holds.
  always_comb begin
    sprite_rgb_next = KEY_COLOR;
    if (region_s1_reg && (code_s1_reg != '0)) begin
      sprite_rgb_next = palette_reg[code_s1_reg];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_rgb_reg <= KEY_COLOR;
    end else begin
      sprite_rgb_reg <= sprite_rgb_next;
    end
  end

  assign sprite_rgb = sprite_rgb_reg;

  logic [3:0] tcnt_reg;
  logic       step;
  logic       wrap;

  // tcnt wraps 15->0 naturally when anim_div is lowered below it.
  assign step = frame_tick && anim_en;
  assign wrap = (tcnt_reg == anim_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_reg <= '0;
    end else if (step) begin
      tcnt_reg <= wrap ? 4'd0 : tcnt_reg + 4'd1;
    end
  end

  generate
    if (FRAMES > 1) begin : g_frame_cnt
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          frame_reg <= '0;
        end else if (step && wrap) begin
          frame_reg <= frame_reg + FB'(1);
        end
      end
    end else begin : g_frame_const
      assign frame_reg = '0;
    end
  endgenerate

endmodule

// File: tb/tb_sprite_anim_src.sv
// Directed bench for sprite_anim_src: arithmetic reference model compared every cycle,
// plus hand-computed literal checks for hits, edges, transparency, animation and reset.
module tb_sprite_anim_src;
  localparam int CD   = 12;
  localparam int PW   = 2;
  localparam int ADDR = 14;
  localparam logic [11:0] KEY = 12'h000;
`ifdef SPRITE_ANIM_HFLIP_EN
  localparam bit HFLIP_ON = 1'b1;
`else
  localparam bit HFLIP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y, x0, y0;
  logic        frame_tick, anim_en, hflip;
  logic [3:0]  anim_div;
  logic [1:0]  cur_frame;
  logic [11:0] sprite_rgb;

  always #5 clk = ~clk;

  sprite_anim_src_if #(.CD(CD), .PW(PW), .ADDR(ADDR)) wr_if ();

  sprite_anim_src #(
    .CD(CD), .PW(PW), .H_SIZE(64), .V_SIZE(64), .FRAMES(4), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .x(x), .y(y), .x0(x0), .y0(y0),
    .frame_tick(frame_tick), .anim_en(anim_en), .anim_div(anim_div), .hflip(hflip),
    .wr(wr_if),
    .cur_frame(cur_frame), .sprite_rgb(sprite_rgb)
  );

  int tests_run = 0;
  int fail_cnt  = 0;
  bit chk_en    = 1'b0;

  // Reference model: pixels computed from coordinates by integer arithmetic.
  bit   [1:0]  ram_m [16384];
  bit          ram_k [16384];
  logic [11:0] pal_m [4];
  int          frame_m, tcnt_m;
  bit          m1_reg, m1_known;
  logic [1:0]  m1_code;
  logic [11:0] m_out;
  bit          m_known;

  always @(posedge clk or negedge reset_n) begin : model
    int xr, yr, col, a;
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) pal_m[i] <= 12'h000;
      frame_m <= 0;
      tcnt_m  <= 0;
      m1_reg  <= 1'b0;
      m_out   <= KEY;
      m_known <= 1'b1;
    end else begin
      if (!m1_reg) begin
        m_out <= KEY; m_known <= 1'b1;
      end else if (!m1_known) begin
        m_known <= 1'b0;
      end else begin
        m_out <= (m1_code == 2'd0) ? KEY : pal_m[m1_code];
        m_known <= 1'b1;
      end
      xr  = int'(x) - int'(x0);
      yr  = int'(y) - int'(y0);
      col = (HFLIP_ON && hflip) ? 63 - (xr & 63) : (xr & 63);
      a   = frame_m * 4096 + (yr & 63) * 64 + col;
      m1_reg   <= (xr >= 0) && (xr < 64) && (yr >= 0) && (yr < 64);
      m1_code  <= ram_m[a];
      m1_known <= ram_k[a];
      if (wr_if.we) begin
        ram_m[wr_if.addr_w] <= wr_if.pixel_in;
        ram_k[wr_if.addr_w] <= 1'b1;
      end
      if (wr_if.plt_we) pal_m[wr_if.plt_addr] <= wr_if.plt_data;
      if (frame_tick && anim_en) begin
        if (tcnt_m == int'(anim_div)) begin
          tcnt_m  <= 0;
          frame_m <= (frame_m + 1) % 4;
        end else begin
          tcnt_m <= (tcnt_m + 1) % 16;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests_run++;
      if (cur_frame !== 2'(frame_m)) begin
        fail_cnt++;
        $display("FAIL model_frame t=%0t: got %0d expected %0d", $time, cur_frame, frame_m);
      end
      if (m_known) begin
        tests_run++;
        if (sprite_rgb !== m_out) begin
          fail_cnt++;
          $display("FAIL model_rgb t=%0t: got %h expected %h", $time, sprite_rgb, m_out);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] %s ok: %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pal_write(input logic [1:0] a, input logic [11:0] d);
    wr_if.plt_we = 1'b1; wr_if.plt_addr = a; wr_if.plt_data = d;
    cyc(1);
    wr_if.plt_we = 1'b0;
  endtask

  task automatic ram_write(input logic [13:0] a, input logic [1:0] d);
    wr_if.we = 1'b1; wr_if.addr_w = a; wr_if.pixel_in = d;
    cyc(1);
    wr_if.we = 1'b0;
  endtask

  task automatic pix(input logic [10:0] xi, input logic [10:0] yi);
    x = xi; y = yi;
    cyc(2);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  int exp_tab [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    x = '0; y = '0; x0 = '0; y0 = '0;
    frame_tick = 1'b0; anim_en = 1'b0; anim_div = 4'd0; hflip = 1'b0;
    wr_if.we = 1'b0; wr_if.addr_w = '0; wr_if.pixel_in = '0;
    wr_if.plt_we = 1'b0; wr_if.plt_addr = '0; wr_if.plt_data = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    cyc(3);
    check("reset_rgb", sprite_rgb, KEY);
    check("reset_frame", cur_frame, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    cyc(2);

    pal_write(2'd1, 12'hF00);
    ram_write(14'd0, 2'd1);
    x0 = 11'd100; y0 = 11'd100;
    pix(11'd100, 11'd100); check("hit_origin", sprite_rgb, 12'hF00);
    pix(11'd99,  11'd100); check("left_of_region", sprite_rgb, KEY);
    pix(11'd164, 11'd100); check("right_of_region", sprite_rgb, KEY);
    pix(11'd100, 11'd99);  check("above_region", sprite_rgb, KEY);
    pix(11'd100, 11'd164); check("below_region", sprite_rgb, KEY);
    ram_write(14'd63, 2'd1);
    pix(11'd163, 11'd100); check("last_column", sprite_rgb, 12'hF00);

    pal_write(2'd0, 12'h0F0);
    ram_write(14'd1, 2'd0);
    pix(11'd101, 11'd100); check("code0_transparent", sprite_rgb, KEY);

    pal_write(2'd3, 12'h0FF);
    x = 11'd100; y = 11'd100;
    wr_if.we = 1'b1; wr_if.addr_w = 14'd0; wr_if.pixel_in = 2'd3;
    cyc(1);
    wr_if.we = 1'b0;
    cyc(1); check("same_addr_old_data", sprite_rgb, 12'hF00);
    cyc(1); check("same_addr_new_data", sprite_rgb, 12'h0FF);

    ram_write(14'd63, 2'd2);
    pal_write(2'd2, 12'h00F);
    ram_write(14'd0, 2'd0);
    hflip = 1'b1;
    pix(11'd100, 11'd100);
    check("hflip_origin", sprite_rgb, HFLIP_ON ? 12'h00F : KEY);
    hflip = 1'b0;

    x = 11'd102;
    anim_div = 4'd2; anim_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("anim_tick%0d", k + 1), cur_frame, exp_tab[k]);
    end
    anim_en = 1'b0;
    repeat (3) tick();
    check("anim_hold", cur_frame, 0);

    anim_en = 1'b1; anim_div = 4'd3;
    tick(); tick();
    anim_div = 4'd1;
    repeat (15) tick();
    check("div_lowered_wrapping", cur_frame, 0);
    tick();
    check("div_lowered_advance", cur_frame, 1);

    anim_div = 4'd0;
    tick();
    check("mid_anim_frame2", cur_frame, 2);
    anim_en = 1'b0;
    ram_write(14'h2000, 2'd1);
    pix(11'd100, 11'd100); check("frame2_pixel", sprite_rgb, 12'hF00);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_frame", cur_frame, 0);
    check("async_reset_rgb", sprite_rgb, KEY);
    cyc(1);
    reset_n = 1'b1;
    ram_write(14'd2, 2'd1);
    pal_write(2'd2, 12'h123);
    ram_write(14'd3, 2'd2);
    pix(11'd102, 11'd100); check("palette_cleared", sprite_rgb, 12'h000);
    pix(11'd103, 11'd100); check("palette_after_reset", sprite_rgb, 12'h123);
    cyc(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
